// File: rtl/clk_powerdn_ctrl.sv
// Power-down controller: counts idle cycles from the gated domain, drops the clock-gate
// enable after an idle window, and re-enables it on wake with a propagation hold-off.
module clk_powerdn_ctrl #(
   parameter int IDLE_CYCLES = 4,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             busy,
   input  logic             wake_req,
   input  logic             force_on,
   output logic             clkgate_e2r,
   output logic             powered,
   output logic [1:0]       pd_state,
   output logic [CNT_W-1:0] idle_cnt,
   output logic [15:0]      gate_count
);

   typedef enum logic [1:0] {
      S_RUN       = 2'd0,
      S_IDLE_WAIT = 2'd1,
      S_GATED     = 2'd2,
      S_WAKE      = 2'd3
   } pd_state_t;

   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

   pd_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      gcnt_q, gcnt_d;
   logic             e2r_q, e2r_d;
   logic             pwr_q, pwr_d;
   logic             activity;

   assign activity = busy | force_on | wake_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
         gcnt_q  <= '0;
         e2r_q   <= 1'b1;
         pwr_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gcnt_q  <= gcnt_d;
         e2r_q   <= e2r_d;
         pwr_q   <= pwr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gcnt_d  = gcnt_q;
      unique case (state_q)
         S_RUN: begin
            cnt_d = '0;
            if (!activity) state_d = S_IDLE_WAIT;
         end
         S_IDLE_WAIT: begin
            if (activity) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else if (cnt_q == IDLE_LAST) begin
               state_d = S_GATED;
               cnt_d   = '0;
               if (gcnt_q != 16'hFFFF) gcnt_d = gcnt_q + 16'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GATED: begin
            if (activity) begin
               state_d = S_WAKE;
               cnt_d   = '0;
            end
         end
         S_WAKE: begin
            // Inputs are deliberately ignored here so the enable settles before re-gating.
            if (cnt_q == WAKE_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
      endcase
      // Outputs are registered copies decoded from the next state.
      e2r_d = (state_d != S_GATED);
      pwr_d = (state_d == S_RUN) || (state_d == S_IDLE_WAIT);
   end

   assign clkgate_e2r = e2r_q;
   assign powered     = pwr_q;
   assign pd_state    = state_q;
   assign idle_cnt    = cnt_q;
   assign gate_count  = gcnt_q;

endmodule

// File: tb/tb_clk_powerdn_ctrl.sv
// Directed and randomized bench for clk_powerdn_ctrl against a timing-rule reference model.
module tb_clk_powerdn_ctrl;

   localparam int IDLE_CYCLES = 4;
   localparam int WAKE_CYCLES = 2;
   localparam int CNT_W       = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             busy, wake_req, force_on;
   logic             clkgate_e2r, powered;
   logic [1:0]       pd_state;
   logic [CNT_W-1:0] idle_cnt;
   logic [15:0]      gate_count;

   int errors = 0;
   int checks = 0;

   // Reference model: idle streak while clocked, gated flag, elapsed wake cycles.
   int          streak;
   bit          gated, waking;
   int          wake_el;
   logic [15:0] m_gc;

   clk_powerdn_ctrl #(
      .IDLE_CYCLES(IDLE_CYCLES),
      .WAKE_CYCLES(WAKE_CYCLES),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .busy       (busy),
      .wake_req   (wake_req),
      .force_on   (force_on),
      .clkgate_e2r(clkgate_e2r),
      .powered    (powered),
      .pd_state   (pd_state),
      .idle_cnt   (idle_cnt),
      .gate_count (gate_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      streak  = 0;
      gated   = 1'b0;
      waking  = 1'b0;
      wake_el = 0;
      m_gc    = 16'd0;
   endtask

   task automatic model_step();
      bit act;
      act = busy | wake_req | force_on;
      if (gated) begin
         if (act) begin
            gated   = 1'b0;
            waking  = 1'b1;
            wake_el = 0;
         end
      end else if (waking) begin
         wake_el++;
         if (wake_el == WAKE_CYCLES) begin
            waking = 1'b0;
            streak = 0;
         end
      end else if (act) begin
         streak = 0;
      end else begin
         streak++;
         if (streak == IDLE_CYCLES + 1) begin
            gated  = 1'b1;
            streak = 0;
            if (m_gc != 16'hFFFF) m_gc = m_gc + 16'd1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [15:0] e_state, e_cnt;
      e_state = gated ? 16'd2 : waking ? 16'd3 : (streak == 0) ? 16'd0 : 16'd1;
      e_cnt   = waking ? 16'(wake_el) : (gated || streak == 0) ? 16'd0 : 16'(streak - 1);
      chk({tag, ".pd_state"}, 16'(pd_state), e_state);
      chk({tag, ".idle_cnt"}, 16'(idle_cnt), e_cnt);
      chk({tag, ".clkgate_e2r"}, 16'(clkgate_e2r), 16'(!gated));
      chk({tag, ".powered"}, 16'(powered), 16'(!gated && !waking));
      chk({tag, ".gate_count"}, gate_count, m_gc);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic b, input logic w, input logic f);
      busy     = b;
      wake_req = w;
      force_on = f;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0);
      model_reset();
      #1;
      check_all("reset_async");
      repeat (3) tick("reset");
      #2 reset = 1'b0;

      // Idle gating, then wake via a one-cycle wake_req pulse.
      drive(1'b0, 1'b0, 1'b0);
      repeat (5) tick("idle_gate");
      drive(1'b0, 1'b1, 1'b0);
      tick("wake_edge");
      drive(1'b0, 1'b0, 1'b0);
      repeat (2) tick("wake_hold");

      // Late abort at idle_cnt==3, then a full idle window.
      repeat (4) tick("abort_idle");
      drive(1'b1, 1'b0, 1'b0);
      tick("abort_busy");
      drive(1'b0, 1'b0, 1'b0);
      repeat (5) tick("abort_regate");
      drive(1'b1, 1'b0, 1'b0);
      repeat (3) tick("abort_wake");

      // force_on inhibits gating.
      drive(1'b0, 1'b0, 1'b1);
      repeat (50) tick("force_on");
      drive(1'b0, 1'b0, 1'b0);
      repeat (5) tick("force_release");

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 31) == 0));
         tick("random");
      end

      // Async reset while gated.
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20 && !gated; i++) tick("to_gated");
      chk("reach_gated", 16'(gated), 16'd1);
      #3 reset = 1'b1;
      #1;
      model_reset();
      check_all("async_reset_gated");
      tick("reset_held");
      #2 reset = 1'b0;
      drive(1'b1, 1'b0, 1'b0);
      tick("post_reset");

      // Saturation of gate_count.
      force dut.gcnt_q = 16'hFFFF;
      m_gc = 16'hFFFF;
      tick("sat_force");
      release dut.gcnt_q;
      tick("sat_release");
      drive(1'b0, 1'b0, 1'b0);
      repeat (6) tick("sat_gate");
      chk("sat_final", gate_count, 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clk_powerdn_ctrl.md
# clk_powerdn_ctrl

Power-down controller that drives the clock-gate enable request consumed by a gated clock domain. It watches activity from that domain, counts idle cycles, and drops the gate enable after a programmable idle window. On a wake event it re-asserts the enable and holds off reporting "powered" until the enable has propagated through the consumer's rise/fall latch pipeline. It sits in the always-on `clk` domain, upstream of the clock-gate latch and the gated logic.

## Interface
- `IDLE_CYCLES`, default 4: consecutive idle cycles required before gating; legal range 1..2^CNT_W-1.
- `WAKE_CYCLES`, default 2: cycles that the enable needs to reach the gated clock after re-assertion; legal range 1..2^CNT_W-1.
- `CNT_W`, default 8: width of the shared idle/wake counter.

- `clk`  in  1  free-running clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `busy`  in  1  activity indication from the gated domain; 1 means work is pending.
- `wake_req`  in  1  external wake request; level-sensitive, sampled on posedge.
- `force_on`  in  1  1 inhibits gating; clock stays enabled.
- `clkgate_e2r`  out  1  gate enable request to the latch pipeline; 1 means clock runs.
- `powered`  out  1  1 means the gated clock is confirmed running.
- `pd_state`  out  2  current FSM state: 0 RUN, 1 IDLE_WAIT, 2 GATED, 3 WAKE.
- `idle_cnt`  out  CNT_W  shared idle/wake counter value.
- `gate_count`  out  16  number of entries into GATED; saturates at 16'hFFFF.

## Operation
- Reset, asynchronous and taking effect immediately without a clock edge:
  - `pd_state`=RUN, `clkgate_e2r`=1, `powered`=1, `idle_cnt`=0, `gate_count`=0.
- RUN (`clkgate_e2r`=1, `powered`=1):
  - If `busy`=0, `force_on`=0 and `wake_req`=0: go to IDLE_WAIT with `idle_cnt`=0.
  - Otherwise stay in RUN.
- IDLE_WAIT (`clkgate_e2r`=1, `powered`=1):
  - If `busy`, `force_on` or `wake_req` is 1: go to RUN with `idle_cnt`=0. This has priority over all other conditions.
  - Else if `idle_cnt`==IDLE_CYCLES-1: go to GATED, set `clkgate_e2r`=0 and `idle_cnt`=0, and increment `gate_count` (saturating).
  - Else: `idle_cnt`+1.
- GATED (`clkgate_e2r`=0, `powered`=0):
  - If `busy`, `wake_req` or `force_on` is 1: go to WAKE, set `clkgate_e2r`=1 and `idle_cnt`=0.
- WAKE (`clkgate_e2r`=1, `powered`=0):
  - All inputs are ignored; re-gating is not possible in this state.
  - If `idle_cnt`==WAKE_CYCLES-1: go to RUN with `powered`=1 and `idle_cnt`=0.
  - Else: `idle_cnt`+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Counter arithmetic is unsigned CNT_W bits. The counter never wraps, because the parameter range guarantees the terminal value fits.
- `gate_count` holds at 16'hFFFF once reached; further gating events do not change it.

## Timing
- Gating latency: with `busy` first sampled 0 at edge E and held idle, `clkgate_e2r` falls after edge E+IDLE_CYCLES.
- Wake latency:
  - A wake event sampled at edge W raises `clkgate_e2r` after edge W.
  - `powered` rises after edge W+WAKE_CYCLES.
- Minimum GATED dwell is 1 cycle. A wake condition already present on the first GATED edge moves the FSM to WAKE on that edge.
- Reset asserted mid-operation (including GATED or WAKE) forces `clkgate_e2r`=1 asynchronously. On reset release the FSM resumes from RUN on the next edge.
- `busy` falling and `wake_req` rising on the same RUN edge: stay in RUN.

## Test plan
- Reset: assert `reset` for 3 cycles with `busy`=1 -> `clkgate_e2r`=1, `powered`=1, `pd_state`=0, `idle_cnt`=0, `gate_count`=0.
- Idle gating (IDLE_CYCLES=4): drop `busy` before edge 0 -> `pd_state`=1 after edge 0; `idle_cnt` reads 0,1,2,3; after edge 4 `pd_state`=2, `clkgate_e2r`=0, `gate_count`=1.
- Late abort: pulse `busy`=1 for one cycle while `idle_cnt`=3 -> `pd_state`=0, `clkgate_e2r` stays 1, `gate_count` unchanged; gating then completes 5 edges after `busy` returns to 0.
- Wake (WAKE_CYCLES=2): in GATED, pulse `wake_req` for one cycle -> after that edge `pd_state`=3, `clkgate_e2r`=1, `powered`=0; after 2 further edges `pd_state`=0, `powered`=1.
- Force-on: hold `force_on`=1 and `busy`=0 for 50 cycles -> `pd_state` stays 0, `gate_count`=0; release `force_on` -> `clkgate_e2r`=0 after the 5th edge.
- Async reset and saturation:
  - Assert `reset` mid-cycle in GATED -> `clkgate_e2r`=1 before the next posedge.
  - With `gate_count` preloaded to 16'hFFFF, a further gating event leaves it at 16'hFFFF.
